// File: rtl/cic_rate_ctrl.sv
// cic_rate_ctrl
//   Owns the decimation setting of the receive CIC decimator. Host requests
//   are validated here and applied only on a CIC output-frame boundary. The
//   first FLUSH_OUTPUTS CIC outputs after reset or after a rate change carry
//   comb-pipeline transients and are suppressed.
//
// Parameters
//   DEC_WIDTH     : width of decimation values
//   DEFAULT_DEC   : decimation applied at reset (must be a legal value)
//   FLUSH_OUTPUTS : CIC outputs discarded after reset / change (1..15)
//
// Ports
//   clock, reset_n          : clock, asynchronous active-low reset
//   req_valid/req_decimation: rate-change request, qualified by req_ready
//   req_ready               : high only in RUN
//   req_ack / req_err       : one-cycle completion / rejection pulses
//   cic_decimation          : registered decimation driven to the CIC
//   cic_out_strobe          : CIC output strobe
//   out_strobe              : qualified output strobe, one cycle behind
//   busy                    : high in PENDING or FLUSH
//
// Optional feature (macro CIC_RATE_CTRL_STATS_EN):
//   stat_changes : saturating count of completed rate changes
//   stat_dropped : saturating count of strobes suppressed while flushing
module cic_rate_ctrl #(
  parameter int DEC_WIDTH     = 6,
  parameter int DEFAULT_DEC   = 40,
  parameter int FLUSH_OUTPUTS = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_valid,
  input  logic [DEC_WIDTH-1:0] req_decimation,
  output logic                 req_ready,
  output logic                 req_ack,
  output logic                 req_err,
  output logic [DEC_WIDTH-1:0] cic_decimation,
  input  logic                 cic_out_strobe,
  output logic                 out_strobe,
  output logic                 busy
`ifdef CIC_RATE_CTRL_STATS_EN
  ,
  output logic [15:0]          stat_changes,
  output logic [15:0]          stat_dropped
`endif
);

  localparam logic [3:0]           FLUSH_INIT = 4'(FLUSH_OUTPUTS);
  localparam logic [DEC_WIDTH-1:0] DEC_INIT   = DEC_WIDTH'(DEFAULT_DEC);

  typedef enum logic [1:0] {
    S_FLUSH   = 2'd0,
    S_RUN     = 2'd1,
    S_PENDING = 2'd2
  } state_t;

  state_t               r_state, w_state_next;
  logic [3:0]           r_fcnt, w_fcnt_next;
  logic [DEC_WIDTH-1:0] r_dec, w_dec_next;
  logic [DEC_WIDTH-1:0] r_pend_dec, w_pend_dec_next;
  logic                 r_chg, w_chg_next;     // current flush follows a rate change
  logic                 r_ack, w_ack_next;
  logic                 r_err, w_err_next;
  logic                 r_ostb, w_ostb_next;
  logic                 w_legal;
  logic                 w_flush_strobe;
  logic                 w_change_done;

  // Only the gain-compensated CIC rates are accepted.
  always_comb begin
    case (32'(req_decimation))
      32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd8,
      32'd10, 32'd12, 32'd20, 32'd24, 32'd40: w_legal = 1'b1;
      default:                                w_legal = 1'b0;
    endcase
  end

  assign w_flush_strobe = (r_state == S_FLUSH) && cic_out_strobe;
  // fcnt <= 1 (not == 1) so a corrupted zero count still exits FLUSH.
  assign w_change_done  = w_flush_strobe && (r_fcnt <= 4'd1) && r_chg;

  always_comb begin
    w_state_next    = r_state;
    w_fcnt_next     = r_fcnt;
    w_dec_next      = r_dec;
    w_pend_dec_next = r_pend_dec;
    w_chg_next      = r_chg;
    w_ack_next      = 1'b0;
    w_err_next      = 1'b0;
    w_ostb_next     = 1'b0;
    case (r_state)
      S_RUN: begin
        w_ostb_next = cic_out_strobe;
        if (req_valid) begin
          if (!w_legal) begin
            w_err_next = 1'b1;
          end else if (req_decimation == r_dec) begin
            w_ack_next = 1'b1;
          end else begin
            w_pend_dec_next = req_decimation;
            w_state_next    = S_PENDING;
          end
        end
      end
      S_PENDING: begin
        // The boundary strobe is still an old-rate output, so it is forwarded.
        w_ostb_next = cic_out_strobe;
        if (cic_out_strobe) begin
          w_dec_next   = r_pend_dec;
          w_fcnt_next  = FLUSH_INIT;
          w_chg_next   = 1'b1;
          w_state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cic_out_strobe) begin
          w_fcnt_next = r_fcnt - 4'd1;
          if (r_fcnt <= 4'd1) begin
            w_fcnt_next  = 4'd0;
            w_ack_next   = r_chg;  // the post-reset flush completes silently
            w_chg_next   = 1'b0;
            w_state_next = S_RUN;
          end
        end
      end
      default: begin
        w_state_next = S_FLUSH;
        w_fcnt_next  = FLUSH_INIT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_FLUSH;
      r_fcnt     <= FLUSH_INIT;
      r_dec      <= DEC_INIT;
      r_pend_dec <= DEC_INIT;
      r_chg      <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_ostb     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fcnt     <= w_fcnt_next;
      r_dec      <= w_dec_next;
      r_pend_dec <= w_pend_dec_next;
      r_chg      <= w_chg_next;
      r_ack      <= w_ack_next;
      r_err      <= w_err_next;
      r_ostb     <= w_ostb_next;
    end
  end

  assign req_ready      = (r_state == S_RUN);
  assign busy           = (r_state != S_RUN);
  assign req_ack        = r_ack;
  assign req_err        = r_err;
  assign out_strobe     = r_ostb;
  assign cic_decimation = r_dec;

`ifdef CIC_RATE_CTRL_STATS_EN
  logic [15:0] r_stat_changes, r_stat_dropped;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_changes <= 16'd0;
      r_stat_dropped <= 16'd0;
    end else begin
      if (w_change_done && (r_stat_changes != 16'hFFFF))
        r_stat_changes <= r_stat_changes + 16'd1;
      if (w_flush_strobe && (r_stat_dropped != 16'hFFFF))
        r_stat_dropped <= r_stat_dropped + 16'd1;
    end
  end

  assign stat_changes = r_stat_changes;
  assign stat_dropped = r_stat_dropped;
`else
  logic w_unused;
  assign w_unused = w_change_done;
`endif

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed testbench for cic_rate_ctrl. Inputs are driven and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_cic_rate_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [5:0] req_decimation = 6'd0;
  logic       req_ready, req_ack, req_err, out_strobe, busy;
  logic [5:0] cic_decimation;
  logic       cic_out_strobe = 1'b0;
`ifdef CIC_RATE_CTRL_STATS_EN
  logic [15:0] stat_changes, stat_dropped;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cic_rate_ctrl #(.DEC_WIDTH(6), .DEFAULT_DEC(40), .FLUSH_OUTPUTS(6)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_decimation(req_decimation),
    .req_ready(req_ready), .req_ack(req_ack), .req_err(req_err),
    .cic_decimation(cic_decimation), .cic_out_strobe(cic_out_strobe),
    .out_strobe(out_strobe), .busy(busy)
`ifdef CIC_RATE_CTRL_STATS_EN
    , .stat_changes(stat_changes), .stat_dropped(stat_dropped)
`endif
  );

  // One CIC output strobe, then 'gap' idle cycles. Called at a falling edge.
  task automatic do_strobe(input int gap, output logic fwd, output logic ack, output logic [5:0] dec);
    cic_out_strobe = 1'b1;
    @(negedge clock);
    cic_out_strobe = 1'b0;
    fwd = out_strobe;
    ack = req_ack;
    dec = cic_decimation;
    repeat (gap) @(negedge clock);
  endtask

  // One-cycle request. Returns after the accepting edge, at a falling edge.
  task automatic do_request(input logic [5:0] d);
    req_valid = 1'b1;
    req_decimation = d;
    @(negedge clock);
    req_valid = 1'b0;
    $display("request decimation=%0d ack=%0b err=%0b busy=%0b dec=%0d", d, req_ack, req_err, busy, cic_decimation);
  endtask

  task automatic test_reset;
    logic fwd, ack, any_ack;
    logic [5:0] dec;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (req_ack !== 1'b0 || req_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got ack=%b err=%b want 0 0", req_ack, req_err); end
    checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL reset_out_strobe: got %b want 0", out_strobe); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    checks++; if (cic_decimation !== 6'd40) begin errors++; $display("FAIL reset_dec: got %0d want 40", cic_decimation); end
    reset_n = 1'b1;
    any_ack = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      do_strobe(39, fwd, ack, dec);
      any_ack |= ack;
      $display("reset-flush strobe %0d fwd=%0b ack=%0b dec=%0d", i, fwd, ack, dec);
      checks++;
      if (fwd !== (i == 7)) begin errors++; $display("FAIL reset_flush_fwd[%0d]: got %b want %b", i, fwd, (i == 7)); end
    end
    checks++; if (any_ack !== 1'b0) begin errors++; $display("FAIL reset_flush_no_ack: got %b want 0", any_ack); end
    checks++; if (cic_decimation !== 6'd40 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_flush_run: got dec=%0d busy=%b ready=%b want 40 0 1", cic_decimation, busy, req_ready); end
  endtask

  task automatic test_same_value;
    logic fwd, ack;
    logic [5:0] dec;
    do_request(6'd40);
    checks++; if (req_ack !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL same_ack: got ack=%b busy=%b want 1 0", req_ack, busy); end
    @(negedge clock);
    checks++; if (req_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL same_ack_pulse: got ack=%b busy=%b want 0 0", req_ack, busy); end
    do_strobe(3, fwd, ack, dec);
    $display("same-value strobe fwd=%0b dec=%0d", fwd, dec);
    checks++; if (fwd !== 1'b1 || dec !== 6'd40) begin errors++; $display("FAIL same_fwd: got fwd=%b dec=%0d want 1 40", fwd, dec); end
  endtask

  task automatic test_rate_change;
    logic fwd, ack;
    logic [5:0] dec;
    do_request(6'd10);
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0 || cic_decimation !== 6'd40) begin
      errors++; $display("FAIL change_pending: got busy=%b ready=%b dec=%0d want 1 0 40", busy, req_ready, cic_decimation); end
    // A request outside RUN is ignored without error.
    do_request(6'd7);
    checks++; if (req_err !== 1'b0 || req_ack !== 1'b0) begin errors++; $display("FAIL change_ignore: got err=%b ack=%b want 0 0", req_err, req_ack); end
    do_strobe(4, fwd, ack, dec);
    $display("boundary strobe fwd=%0b dec=%0d", fwd, dec);
    checks++; if (fwd !== 1'b1 || dec !== 6'd10) begin errors++; $display("FAIL change_boundary: got fwd=%b dec=%0d want 1 10", fwd, dec); end
    for (int i = 1; i <= 6; i++) begin
      do_strobe(0, fwd, ack, dec);
      $display("change-flush strobe %0d fwd=%0b ack=%0b", i, fwd, ack);
      checks++; if (fwd !== 1'b0 || ack !== (i == 6)) begin
        errors++; $display("FAIL change_flush[%0d]: got fwd=%b ack=%b want 0 %b", i, fwd, ack, (i == 6)); end
      repeat (3) @(negedge clock);
    end
    checks++; if (req_ack !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL change_run: got ack=%b busy=%b ready=%b want 0 0 1", req_ack, busy, req_ready); end
  endtask

  task automatic test_illegal;
    logic [5:0] bad [2] = '{6'd7, 6'd0};
    for (int i = 0; i < 2; i++) begin
      do_request(bad[i]);
      checks++; if (req_err !== 1'b1 || req_ack !== 1'b0) begin
        errors++; $display("FAIL illegal_err[%0d]: got err=%b ack=%b want 1 0", bad[i], req_err, req_ack); end
      @(negedge clock);
      checks++; if (req_err !== 1'b0 || busy !== 1'b0 || cic_decimation !== 6'd10) begin
        errors++; $display("FAIL illegal_state[%0d]: got err=%b busy=%b dec=%0d want 0 0 10", bad[i], req_err, busy, cic_decimation); end
    end
  endtask

  task automatic test_reset_in_flush;
    logic fwd, ack, any_ack;
    logic [5:0] dec;
    do_request(6'd2);
    do_strobe(2, fwd, ack, dec);
    checks++; if (fwd !== 1'b1 || dec !== 6'd2) begin errors++; $display("FAIL rif_boundary: got fwd=%b dec=%0d want 1 2", fwd, dec); end
    do_strobe(2, fwd, ack, dec);
    checks++; if (fwd !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rif_flush: got fwd=%b busy=%b want 0 1", fwd, busy); end
    reset_n = 1'b0;
    #1;
    $display("reset asserted during flush dec=%0d busy=%0b", cic_decimation, busy);
    checks++; if (cic_decimation !== 6'd40 || busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL rif_async: got dec=%0d busy=%b ready=%b want 40 1 0", cic_decimation, busy, req_ready); end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    any_ack = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      do_strobe(3, fwd, ack, dec);
      any_ack |= ack;
      checks++; if (fwd !== (i == 7)) begin errors++; $display("FAIL rif_reflush[%0d]: got %b want %b", i, fwd, (i == 7)); end
    end
    checks++; if (any_ack !== 1'b0 || cic_decimation !== 6'd40) begin
      errors++; $display("FAIL rif_end: got ack=%b dec=%0d want 0 40", any_ack, cic_decimation); end
  endtask

  task automatic test_back_to_back;
    logic fwd, ack;
    logic [5:0] dec;
    // Acceptance and a CIC strobe in the same cycle: strobe forwarded, change waits.
    req_valid = 1'b1;
    req_decimation = 6'd10;
    cic_out_strobe = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    cic_out_strobe = 1'b0;
    $display("coincident request+strobe out=%0b busy=%0b dec=%0d", out_strobe, busy, cic_decimation);
    checks++; if (out_strobe !== 1'b1 || busy !== 1'b1 || cic_decimation !== 6'd40) begin
      errors++; $display("FAIL b2b_coincident: got out=%b busy=%b dec=%0d want 1 1 40", out_strobe, busy, cic_decimation); end
    repeat (3) @(negedge clock);
    do_strobe(1, fwd, ack, dec);
    checks++; if (fwd !== 1'b1 || dec !== 6'd10) begin errors++; $display("FAIL b2b_boundary: got fwd=%b dec=%0d want 1 10", fwd, dec); end
    for (int i = 1; i <= 6; i++) begin
      do_strobe(1, fwd, ack, dec);
      checks++; if (fwd !== 1'b0 || ack !== (i == 6)) begin
        errors++; $display("FAIL b2b_flush[%0d]: got fwd=%b ack=%b want 0 %b", i, fwd, ack, (i == 6)); end
    end
    checks++; if (busy !== 1'b0 || req_ack !== 1'b0) begin errors++; $display("FAIL b2b_run: got busy=%b ack=%b want 0 0", busy, req_ack); end
`ifdef CIC_RATE_CTRL_STATS_EN
    // Since the last reset: one completed change, 6 + 6 suppressed strobes.
    checks++; if (stat_changes !== 16'd1 || stat_dropped !== 16'd12) begin
      errors++; $display("FAIL stats: got changes=%0d dropped=%0d want 1 12", stat_changes, stat_dropped); end
`endif
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_same_value();
    test_rate_change();
    test_illegal();
    test_reset_in_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_rate_ctrl.md
# cic_rate_ctrl

Sequencer that owns the decimation setting of the receive CIC decimator. Host rate-change requests are accepted and validated here, then applied only on a CIC output-frame boundary so the CIC sample counter never overruns. The first outputs after every change and after reset carry comb-pipeline transients, so this block suppresses them. It sits between the host control registers and the CIC, and gates the CIC output strobe toward the downstream FIFO/packetiser.

## Interface
- `DEC_WIDTH`, 6: width of decimation values.
- `DEFAULT_DEC`, 40: decimation applied at reset. Must be a legal value.
- `FLUSH_OUTPUTS`, 6: number of CIC outputs discarded after reset or after a rate change. Range 1..15.

Ports:
- `clock`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: rate-change request, qualified by `req_ready`.
- `req_decimation`, in, DEC_WIDTH: requested decimation.
- `req_ready`, out, 1: high only in RUN.
- `req_ack`, out, 1: one-cycle pulse when a legal request completes (applied, or already current).
- `req_err`, out, 1: one-cycle pulse when an illegal request is rejected.
- `cic_decimation`, out, DEC_WIDTH: registered decimation driven to the CIC.
- `cic_out_strobe`, in, 1: output strobe from the CIC.
- `out_strobe`, out, 1: qualified output strobe to downstream.
- `busy`, out, 1: high in PENDING or FLUSH.

## Operation
- Legal decimations: 2, 3, 4, 5, 6, 8, 10, 12, 20, 24, 40. These are the CIC's gain-compensated rates. Any other value is illegal.
- States: FLUSH, RUN, PENDING. The flush counter `fcnt` is 4 bits.
- Reset:
  - State = FLUSH, `fcnt` = FLUSH_OUTPUTS, `cic_decimation` = DEFAULT_DEC.
  - `req_ready` = `req_ack` = `req_err` = `out_strobe` = 0, `busy` = 1.
- RUN:
  - `out_strobe` is `cic_out_strobe` delayed one cycle.
  - On `req_valid`, with an illegal value: pulse `req_err`, stay in RUN.
  - With a legal value equal to `cic_decimation`: pulse `req_ack`, stay in RUN.
  - With a legal value that differs: latch it into `pend_dec` and go to PENDING.
- PENDING:
  - `req_ready` = 0. Outputs at the old rate still pass to `out_strobe`.
  - On `cic_out_strobe`: load `cic_decimation` <= `pend_dec`, load `fcnt` <= FLUSH_OUTPUTS, go to FLUSH.
  - The boundary strobe itself is forwarded; it is the last valid old-rate output.
- FLUSH:
  - `out_strobe` is forced to 0.
  - Each `cic_out_strobe` decrements `fcnt`.
  - On the strobe that takes `fcnt` from 1 to 0, go to RUN and pulse `req_ack`. After reset, no `req_ack` is pulsed.
- The change is applied in the same cycle the CIC resets its sample counter to 0, so the next input sample starts the new frame. Because the old decimation is at least 2, an input strobe coincident with the boundary cannot trigger a spurious output.

## Timing
- `out_strobe` lags `cic_out_strobe` by 1 cycle.
- Request acceptance is in the same cycle as `req_valid && req_ready`.
- `req_err` and the same-value `req_ack` assert on the next cycle.
- `cic_decimation` updates on the clock edge at which PENDING sees `cic_out_strobe`.
- The change-path `req_ack` follows the FLUSH_OUTPUTS-th discarded strobe by 1 cycle.
- `req_valid` outside RUN is ignored; no error is flagged.
- `cic_out_strobe` arriving in the same cycle as acceptance is forwarded. The change then waits for the next boundary.
- Asserting reset in any state returns the block immediately to the reset values. `cic_decimation` returns to DEFAULT_DEC and any pending request is dropped.

## Configuration
- `CIC_RATE_CTRL_STATS_EN` defined: adds two outputs, each 16 bits, saturating at 0xFFFF, cleared only by reset.
  - `stat_changes` increments on each change-path `req_ack`.
  - `stat_dropped` increments on each strobe suppressed in FLUSH.
- Not defined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset then strobes every 40 cycles: the first 6 strobes are suppressed, `out_strobe` is seen from the 7th, `cic_decimation` = 40, `req_ack` never pulses.
- In RUN, request 10 mid-frame: `busy` = 1 and `req_ready` = 0.
  - The next CIC strobe is forwarded and `cic_decimation` becomes 10 on that edge.
  - 6 strobes are then suppressed, `req_ack` pulses once, and RUN resumes.
- Request 7, then 0: a `req_err` pulse for each, `cic_decimation` unchanged, state stays RUN.
- Request 40 while at 40: `req_ack` one cycle later, `busy` never asserts, no strobes dropped.
- Assert reset during FLUSH after a change to 2: `cic_decimation` = 40 immediately, and 6 strobes are discarded again after release.
- With `CIC_RATE_CTRL_STATS_EN`, two changes and one reset-flush: `stat_changes` = 2, `stat_dropped` = 18.
